// File: rtl/ecc_mem_ctrl.sv
// ECC-protected single-port SRAM controller: (38,32) encode on write, decode/correct on
// read, and write-back of corrected words.
module ecc_mem_ctrl #(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  output logic          wr_ack,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ack,
  output logic [31:0]   rd_data,
  output logic          rd_err_cor,
  output logic          rd_err_unc,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [37:0]   mem_wdata,
  input  logic [37:0]   mem_rdata,
  output logic [7:0]    cnt_cor,
  output logic [7:0]    cnt_unc,
  input  logic          cnt_clr
);

  typedef enum logic [2:0] {StIdle, StWr, StRd, StChk, StScrb} state_e;

  // Data-bit columns of the check matrix; must match ecc_enc_module.
  localparam logic [5:0] Col [32] = '{
    6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
    6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
  };

  state_e        state_q, state_d;
  logic          last_rd_q;
  logic [AW-1:0] addr_q;
  logic          rd_ack_q;
  logic [31:0]   rd_data_q;
  logic          cor_q, unc_q;
  logic [7:0]    cnt_cor_q, cnt_unc_q;

  logic [31:0]   enc_data;
  logic [5:0]    enc_chk;
  logic [5:0]    rd_chk;
  logic [5:0]    syn;
  logic [31:0]   flip;
  logic          dec_cor, dec_unc;
  logic [31:0]   dec_data;

  ecc_enc_module u_enc (
    .data_i  (enc_data),
    .check_o (enc_chk)
  );

  ecc_enc_module u_syn (
    .data_i  (mem_rdata[31:0]),
    .check_o (rd_chk)
  );

  // Check-bit inversions appear on both sides of the XOR and cancel.
  always_comb begin
    syn  = mem_rdata[37:32] ^ rd_chk;
    flip = '0;
    for (int j = 0; j < 32; j++) begin
      if (syn == Col[j]) flip[j] = 1'b1;
    end
    dec_cor  = (syn != '0) && ($onehot(syn) || (flip != '0));
    dec_unc  = (syn != '0) && !dec_cor;
    dec_data = mem_rdata[31:0] ^ flip;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (wr_req && rd_req) state_d = last_rd_q ? StWr : StRd;
        else if (wr_req)      state_d = StWr;
        else if (rd_req)      state_d = StRd;
      end
      StWr:    state_d = StIdle;
      StRd:    state_d = StChk;
      StChk:   state_d = dec_cor ? StScrb : StIdle;
      StScrb:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_ack    = 1'b0;
    enc_data  = wr_data;
    unique case (state_q)
      StWr: begin
        mem_ce    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = {enc_chk, wr_data};
        wr_ack    = 1'b1;
      end
      StRd: begin
        mem_ce   = 1'b1;
        mem_addr = rd_addr;
      end
      StScrb: begin
        enc_data  = rd_data_q;
        mem_ce    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = {enc_chk, rd_data_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_rd_q <= 1'b0;
      addr_q    <= '0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      cor_q     <= 1'b0;
      unc_q     <= 1'b0;
    end else begin
      if (state_q == StIdle && state_d == StWr) last_rd_q <= 1'b0;
      if (state_q == StIdle && state_d == StRd) last_rd_q <= 1'b1;
      if (state_q == StRd) addr_q <= rd_addr;
      rd_ack_q <= (state_q == StChk);
      if (state_q == StChk) begin
        rd_data_q <= dec_data;
        cor_q     <= dec_cor;
        unc_q     <= dec_unc;
      end
    end
  end

  // Clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_cor_q <= '0;
      cnt_unc_q <= '0;
    end else if (rd_ack_q) begin
      if (cor_q && cnt_cor_q != 8'hFF) cnt_cor_q <= cnt_cor_q + 8'd1;
      if (unc_q && cnt_unc_q != 8'hFF) cnt_unc_q <= cnt_unc_q + 8'd1;
    end
  end

  assign rd_ack     = rd_ack_q;
  assign rd_data    = rd_data_q;
  assign rd_err_cor = cor_q;
  assign rd_err_unc = unc_q;
  assign cnt_cor    = cnt_cor_q;
  assign cnt_unc    = cnt_unc_q;

endmodule

// (38,32) check-bit encoder: each data bit XORs its column into the check bits,
// then a fixed inversion pattern is applied so an all-zero word has non-zero check bits.
module ecc_enc_module (
  input  logic [31:0] data_i,
  output logic [5:0]  check_o
);

  localparam logic [5:0] Inv = 6'b100101;
  localparam logic [5:0] Col [32] = '{
    6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
    6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
  };

  logic [5:0] acc;

  always_comb begin
    acc = '0;
    for (int j = 0; j < 32; j++) begin
      if (data_i[j]) acc = acc ^ Col[j];
    end
    check_o = acc ^ Inv;
  end

endmodule

// File: tb/tb_ecc_mem_ctrl.sv
// Self-checking bench for ecc_mem_ctrl: SRAM model, directed scenarios and a randomized
// read/write mix checked against a brute-force single-bit-correction reference.
module tb_ecc_mem_ctrl;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst, wr_req, rd_req, cnt_clr;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [31:0]   wr_data;
  logic          wr_ack, rd_ack, rd_err_cor, rd_err_unc;
  logic [31:0]   rd_data;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [37:0]   mem_wdata, mem_rdata;
  logic [7:0]    cnt_cor, cnt_unc;

  ecc_mem_ctrl #(.AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data),
    .rd_err_cor (rd_err_cor),
    .rd_err_unc (rd_err_unc),
    .mem_ce     (mem_ce),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .cnt_cor    (cnt_cor),
    .cnt_unc    (cnt_unc),
    .cnt_clr    (cnt_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int nwr = 0, nwack = 0, nrack = 0, nboth = 0;
  logic [7:0]  last_wa;
  logic [37:0] last_wd;
  int exp_cor = 0, exp_unc = 0;
  logic [31:0] ref_data [256];
  logic [37:0] sram [256];
  logic [37:0] rdata_q;

  assign mem_rdata = rdata_q;

  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) sram[mem_addr] = mem_wdata;
      else        rdata_q <= sram[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (mem_ce && mem_we) begin
      nwr++;
      last_wa = mem_addr;
      last_wd = mem_wdata;
    end
    if (wr_ack) nwack++;
    if (rd_ack) nrack++;
    if (wr_ack && rd_ack) nboth++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Column of data bit j is the j-th integer >= 3 that is not a power of two.
  function automatic logic [5:0] enc_ref(input logic [31:0] d);
    logic [5:0] c;
    int unsigned v;
    c = 6'b100101;
    v = 2;
    for (int j = 0; j < 32; j++) begin
      v++;
      while ((v & (v - 1)) == 0) v++;
      if (d[j]) c = c ^ v[5:0];
    end
    return c;
  endfunction

  function automatic logic [37:0] cw_of(input logic [31:0] d);
    return {enc_ref(d), d};
  endfunction

  // Reference decode: accept the word, or find the single bit flip that makes it consistent.
  task automatic decode_ref(input logic [37:0] cw, output logic [31:0] d,
                            output logic c, output logic u);
    logic [37:0] t;
    d = cw[31:0];
    c = 1'b0;
    u = 1'b0;
    if (cw[37:32] != enc_ref(cw[31:0])) begin
      u = 1'b1;
      for (int i = 0; i < 38; i++) begin
        t = cw;
        t[i] = ~t[i];
        if (u && t[37:32] == enc_ref(t[31:0])) begin
          d = t[31:0];
          c = 1'b1;
          u = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    cnt_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    exp_cor = 0;
    exp_unc = 0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, output int lat);
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    lat     = 99;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (wr_ack) begin
        lat = i;
        break;
      end
    end
    wr_req = 1'b0;
    step();
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic c,
                         output logic u, output int lat);
    rd_addr = a;
    rd_req  = 1'b1;
    lat = 99;
    d = '0;
    c = 1'b0;
    u = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (rd_ack) begin
        lat = i;
        d = rd_data;
        c = rd_err_cor;
        u = rd_err_unc;
        break;
      end
    end
    rd_req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if ({wr_ack, rd_ack, mem_ce, mem_we} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {wr_ack, rd_ack, mem_ce, mem_we});
    end
    n_tests++; if ({rd_data, rd_err_cor, rd_err_unc} !== 34'b0) begin
      n_fail++; $display("FAIL reset_rd: got %h want 0", {rd_data, rd_err_cor, rd_err_unc});
    end
    n_tests++; if ({cnt_cor, cnt_unc} !== 16'h0) begin
      n_fail++; $display("FAIL reset_cnt: got %h want 0000", {cnt_cor, cnt_unc});
    end
  endtask

  task automatic test_write();
    int lat, w0, a0;
    w0 = nwr;
    a0 = nwack;
    do_write(8'h05, 32'hDEADBEEF, lat);
    ref_data[5] = 32'hDEADBEEF;
    n_tests++; if (lat !== 1) begin
      n_fail++; $display("FAIL wr_latency: got %0d want 1", lat);
    end
    n_tests++; if (nwr - w0 !== 1) begin
      n_fail++; $display("FAIL wr_count: got %0d want 1", nwr - w0);
    end
    n_tests++; if (last_wa !== 8'h05) begin
      n_fail++; $display("FAIL wr_addr: got %h want 05", last_wa);
    end
    n_tests++; if (last_wd !== cw_of(32'hDEADBEEF)) begin
      n_fail++; $display("FAIL wr_codeword: got %h want %h", last_wd, cw_of(32'hDEADBEEF));
    end
    n_tests++; if (nwack - a0 !== 1) begin
      n_fail++; $display("FAIL wr_ack_once: got %0d want 1", nwack - a0);
    end
  endtask

  task automatic test_read_clean();
    logic [31:0] d;
    logic c, u;
    int lat, w0;
    w0 = nwr;
    do_read(8'h05, d, c, u, lat);
    n_tests++; if (lat !== 3) begin
      n_fail++; $display("FAIL rd_latency: got %0d want 3", lat);
    end
    n_tests++; if (d !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd_clean_data: got %h want deadbeef", d);
    end
    n_tests++; if ({c, u} !== 2'b00) begin
      n_fail++; $display("FAIL rd_clean_flags: got %b want 00", {c, u});
    end
    n_tests++; if (nwr !== w0) begin
      n_fail++; $display("FAIL rd_clean_noscrub: got %0d writes want 0", nwr - w0);
    end
  endtask

  task automatic test_read_cor();
    logic [31:0] d;
    logic c, u;
    int lat, w0;
    sram[5] = cw_of(32'hDEADBEEF) ^ 38'h1;
    w0 = nwr;
    do_read(8'h05, d, c, u, lat);
    n_tests++; if (d !== 32'hDEADBEEF || {c, u} !== 2'b10) begin
      n_fail++; $display("FAIL rd_cor: got %h cor=%b unc=%b want deadbeef 1 0", d, c, u);
    end
    n_tests++; if (nwr - w0 !== 1 || sram[5] !== cw_of(32'hDEADBEEF)) begin
      n_fail++; $display("FAIL scrub_write: got %0d writes %h want 1 %h",
                         nwr - w0, sram[5], cw_of(32'hDEADBEEF));
    end
    n_tests++; if (cnt_cor !== 8'd1) begin
      n_fail++; $display("FAIL cnt_cor_one: got %0d want 1", cnt_cor);
    end
    w0 = nwr;
    do_read(8'h05, d, c, u, lat);
    n_tests++; if (d !== 32'hDEADBEEF || {c, u} !== 2'b00 || nwr !== w0) begin
      n_fail++; $display("FAIL reread_clean: got %h cor=%b unc=%b want deadbeef 0 0", d, c, u);
    end
    exp_cor = 1;
  endtask

  task automatic test_read_unc();
    logic [31:0] d;
    logic c, u;
    int lat, w0;
    sram[5] = cw_of(32'hDEADBEEF) ^ 38'h3C_0000_0000;
    w0 = nwr;
    do_read(8'h05, d, c, u, lat);
    n_tests++; if (d !== 32'hDEADBEEF || {c, u} !== 2'b01) begin
      n_fail++; $display("FAIL rd_unc: got %h cor=%b unc=%b want deadbeef 0 1", d, c, u);
    end
    n_tests++; if (nwr !== w0) begin
      n_fail++; $display("FAIL unc_noscrub: got %0d writes want 0", nwr - w0);
    end
    n_tests++; if (cnt_unc !== 8'd1) begin
      n_fail++; $display("FAIL cnt_unc_one: got %0d want 1", cnt_unc);
    end
    exp_unc = 1;
    sram[5] = cw_of(32'hDEADBEEF);
  endtask

  task automatic test_random();
    logic [7:0]  a;
    logic [31:0] d, ed;
    logic [37:0] t;
    logic c, u, ec, eu;
    int lat, w0, nf;
    for (int it = 0; it < 80; it++) begin
      a = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom;
        do_write(a, d, lat);
        ref_data[a] = d;
        n_tests++; if (lat !== 1 || sram[a] !== cw_of(d)) begin
          n_fail++; $display("FAIL rand_write: got lat=%0d %h want 1 %h", lat, sram[a], cw_of(d));
        end
      end else begin
        nf = $urandom_range(0, 2);
        t = sram[a];
        for (int k = 0; k < nf; k++) begin
          int b;
          b = $urandom_range(0, 37);
          t[b] = ~t[b];
        end
        sram[a] = t;
        decode_ref(t, ed, ec, eu);
        w0 = nwr;
        do_read(a, d, c, u, lat);
        n_tests++; if (d !== ed || c !== ec || u !== eu || lat !== 3) begin
          n_fail++; $display("FAIL rand_read: got %h %b%b lat=%0d want %h %b%b lat=3",
                             d, c, u, lat, ed, ec, eu);
        end
        n_tests++; if ((nwr - w0) !== (ec ? 1 : 0) || (ec && sram[a] !== cw_of(ed))) begin
          n_fail++; $display("FAIL rand_scrub: got %0d writes %h want %0d %h",
                             nwr - w0, sram[a], ec ? 1 : 0, cw_of(ed));
        end
        if (ec) exp_cor = (exp_cor < 255) ? exp_cor + 1 : 255;
        if (eu) exp_unc = (exp_unc < 255) ? exp_unc + 1 : 255;
        n_tests++; if (cnt_cor !== 8'(exp_cor) || cnt_unc !== 8'(exp_unc)) begin
          n_fail++; $display("FAIL rand_counters: got %0d/%0d want %0d/%0d",
                             cnt_cor, cnt_unc, exp_cor, exp_unc);
        end
        sram[a] = cw_of(ref_data[a]);
      end
    end
  endtask

  task automatic test_unc_saturate();
    logic [31:0] d;
    logic c, u;
    int lat;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    exp_cor = 0;
    exp_unc = 0;
    sram[200] = cw_of(32'h1234_5678) ^ 38'h3C_0000_0000;
    for (int i = 0; i < 257; i++) begin
      do_read(8'd200, d, c, u, lat);
      if (i == 254) begin
        n_tests++; if (cnt_unc !== 8'd255) begin
          n_fail++; $display("FAIL unc_reach_255: got %0d want 255", cnt_unc);
        end
      end
    end
    n_tests++; if (cnt_unc !== 8'd255 || cnt_cor !== 8'd0) begin
      n_fail++; $display("FAIL unc_saturate: got %0d/%0d want 255/0", cnt_unc, cnt_cor);
    end
    sram[200] = cw_of(32'h0);
  endtask

  task automatic test_clr_coincident();
    logic got;
    got = 1'b0;
    sram[5] = cw_of(32'hDEADBEEF) ^ 38'h8;
    rd_addr = 8'h05;
    rd_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (rd_ack) begin
        got = 1'b1;
        cnt_clr = 1'b1;
        break;
      end
    end
    rd_req = 1'b0;
    step();
    cnt_clr = 1'b0;
    step();
    n_tests++; if (got !== 1'b1) begin
      n_fail++; $display("FAIL clr_ack_seen: got %b want 1", got);
    end
    n_tests++; if (cnt_cor !== 8'd0 || cnt_unc !== 8'd0) begin
      n_fail++; $display("FAIL clr_priority: got %0d/%0d want 0/0", cnt_cor, cnt_unc);
    end
    n_tests++; if (sram[5] !== cw_of(32'hDEADBEEF)) begin
      n_fail++; $display("FAIL clr_scrub: got %h want %h", sram[5], cw_of(32'hDEADBEEF));
    end
    exp_cor = 0;
    exp_unc = 0;
  endtask

  task automatic test_reset_in_chk();
    logic [37:0] stored;
    int w0, r0;
    stored = cw_of(32'hDEADBEEF) ^ 38'h2;
    sram[5] = stored;
    rd_addr = 8'h05;
    rd_req = 1'b1;
    step();
    step();
    w0 = nwr;
    r0 = nrack;
    rst = 1'b1;
    rd_req = 1'b0;
    step();
    n_tests++; if (mem_ce !== 1'b0 || rd_ack !== 1'b0) begin
      n_fail++; $display("FAIL rst_chk_idle: got ce=%b ack=%b want 0 0", mem_ce, rd_ack);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    n_tests++; if (nrack !== r0 || nwr !== w0) begin
      n_fail++; $display("FAIL rst_chk_abort: got %0d acks %0d writes want 0 0",
                         nrack - r0, nwr - w0);
    end
    n_tests++; if (sram[5] !== stored) begin
      n_fail++; $display("FAIL rst_chk_mem: got %h want %h", sram[5], stored);
    end
    sram[5] = cw_of(32'hDEADBEEF);
    exp_cor = 0;
    exp_unc = 0;
  endtask

  task automatic test_back_to_back();
    int seq[$];
    int exp_seq[4];
    exp_seq = '{1, 0, 1, 0};
    apply_reset();
    wr_addr = 8'h05;
    wr_data = 32'hDEADBEEF;
    rd_addr = 8'h05;
    wr_req = 1'b1;
    rd_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rd_ack) seq.push_back(1);
      if (wr_ack) seq.push_back(0);
      if (seq.size() >= 4) break;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    step();
    step();
    n_tests++; if (seq.size() !== 4) begin
      n_fail++; $display("FAIL arb_count: got %0d acks want 4", seq.size());
    end
    for (int k = 0; k < 4; k++) begin
      if (k < seq.size()) begin
        n_tests++; if (seq[k] !== exp_seq[k]) begin
          n_fail++; $display("FAIL arb_order[%0d]: got %s want %s", k,
                             seq[k] == 1 ? "R" : "W", exp_seq[k] == 1 ? "R" : "W");
        end
      end
    end
    n_tests++; if (nboth !== 0) begin
      n_fail++; $display("FAIL ack_overlap: got %0d cycles want 0", nboth);
    end
  endtask

  initial begin
    rst = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    cnt_clr = 1'b0;
    wr_addr = '0;
    rd_addr = '0;
    wr_data = '0;
    for (int i = 0; i < 256; i++) begin
      sram[i] = cw_of(32'h0);
      ref_data[i] = 32'h0;
    end
    test_reset();
    test_write();
    test_read_clean();
    test_read_cor();
    test_read_unc();
    test_random();
    test_unc_saturate();
    test_clr_coincident();
    test_reset_in_chk();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_mem_ctrl.md
ECC_MEM_CTRL -- requirements
Module: ecc_mem_ctrl

Interface
REQ-001 Parameter: AW, default 8, memory address width.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 wr_req  input  1  write request; held with wr_addr/wr_data until wr_ack.
REQ-005 wr_addr  input  AW  write word address.
REQ-006 wr_data  input  32  write data.
REQ-007 wr_ack  output  1  one-cycle write-accepted pulse.
REQ-008 rd_req  input  1  read request; held with rd_addr until rd_ack.
REQ-009 rd_addr  input  AW  read word address.
REQ-010 rd_ack  output  1  one-cycle pulse; rd_data and flags valid.
REQ-011 rd_data  output  32  corrected read data.
REQ-012 rd_err_cor  output  1  single error corrected, valid with rd_ack.
REQ-013 rd_err_unc  output  1  uncorrectable error, valid with rd_ack.
REQ-014 mem_ce  output  1  SRAM chip enable.
REQ-015 mem_we  output  1  SRAM write enable, qualified by mem_ce.
REQ-016 mem_addr  output  AW  SRAM address.
REQ-017 mem_wdata  output  38  codeword {check[5:0], data[31:0]}.
REQ-018 mem_rdata  input  38  codeword, valid one cycle after a mem_ce read.
REQ-019 cnt_cor  output  8  saturating corrected-error count.
REQ-020 cnt_unc  output  8  saturating uncorrectable-error count.
REQ-021 cnt_clr  input  1  synchronous clear of both counters.

Function
REQ-022 Encoding SHALL use one instance of the team's (38,32) encoder, ecc_enc_module; its check bits include constant inversions.
REQ-023 Syndrome SHALL be mem_rdata[37:32] XOR the encoder check bits of mem_rdata[31:0], using a second encoder instance; the inversions cancel.
REQ-024 Decode: syndrome 0 -> clean; weight-1 syndrome -> check-bit error, data unchanged, cor=1; syndrome equal to a data-bit column -> flip that bit, cor=1; otherwise unc=1 and raw data is returned.
REQ-025 FSM states SHALL be IDLE, WR, RD, CHK and SCRB.
REQ-026 IDLE: requests are sampled only in IDLE. Only wr_req -> WR; only rd_req -> RD. Both -> grant the port not granted last (last_grant flag). Neither -> stay in IDLE.
REQ-027 WR (1 cycle): mem_ce=1, mem_we=1, mem_addr=wr_addr, mem_wdata=encoded wr_data, wr_ack=1; next state IDLE.
REQ-028 RD (1 cycle): mem_ce=1, mem_we=0, mem_addr=rd_addr; address is latched; next state CHK.
REQ-029 CHK: decode mem_rdata; register rd_data and flags; rd_ack=1 in the following cycle. Next state is SCRB if cor=1, else IDLE.
REQ-030 SCRB (1 cycle): write the re-encoded corrected data to the latched address with mem_ce=1, mem_we=1; next state IDLE.
REQ-031 Latency: write, wr_ack 1 cycle after grant. Read, rd_ack 3 cycles after grant. Read throughput is 1 per 3 cycles, or 4 with scrub.
REQ-032 mem_ce SHALL be 0 in IDLE and CHK; mem_wdata and mem_addr are don't-care when mem_ce=0.
REQ-033 Counters SHALL increment by 1 per rd_ack carrying the matching flag and saturate at 255. cnt_clr has priority; a same-cycle increment is dropped.
REQ-034 wr_ack and rd_ack SHALL never assert in the same cycle, and each SHALL assert at most once per request.

Reset
REQ-035 While rst is sampled high: the state goes to IDLE; all outputs go to 0; last_grant = write, so a read wins the first tie; counters go to 0.
REQ-036 Reset mid-operation SHALL abort the operation with no ack and no SCRB write; mem_ce=0 from the cycle after rst is sampled.

Verification
REQ-037 Reset, then write 0xDEADBEEF to address 0x05 -> one cycle with mem_we=1, mem_addr=0x05, mem_wdata[31:0]=0xDEADBEEF, check bits equal to encoder output; wr_ack pulses once.
REQ-038 Read address 0x05, clean -> rd_ack 3 cycles after grant; rd_data=0xDEADBEEF; cor=0, unc=0; no SCRB write.
REQ-039 SRAM model flips bit 0 at address 0x05, then read -> rd_data=0xDEADBEEF, cor=1; the SCRB write restores the original codeword; cnt_cor=1. Re-read is clean.
REQ-040 Flip codeword bits 37..34 (weight-4 syndrome), then read -> unc=1, rd_data=0xDEADBEEF, no SCRB, cnt_unc=1.
REQ-041 wr_req and rd_req asserted together continuously after reset -> grants alternate R, W, R, W. wr_ack and rd_ack are never simultaneous.
REQ-042 cnt_clr coincident with a corrected rd_ack -> cnt_cor=0. Reset asserted during CHK -> no rd_ack and no SCRB write.
